fba_alu: RTL and testbench

Bit-serial 1-bit function-block ALU (FBA) for the serial adder CPU.
- Consumes one bit of operand A and one bit of operand B per clock, LSB first. Operands come from the Parallel_To_Serial shifters.
- Produces one result bit per clock. The result is captured by a Serial_To_Parallel shifter, which shifts right and enters each new bit at the MSB.
- A single carry flip-flop chains bits so multi-bit add and carry-generation work serially.

---
 rtl/fba_pkg.sv | 17 +
 rtl/fba_alu_if.sv | 32 +++
 rtl/fba_full_adder.sv | 16 +
 rtl/fba_alu.sv | 62 ++++++
 tb/tb_fba_alu.sv | 139 +++++++++++++
 5 files changed

// File: rtl/fba_pkg.sv
// rtl/fba_pkg.sv - shared function encoding for the bit-serial FBA ALU
package fba_pkg;

  localparam int FBA_FUNC_W = 3;

  typedef enum logic [FBA_FUNC_W-1:0] {
    XOR    = 3'd0,
    XNOR   = 3'd1,
    SUM    = 3'd2,
    NOT    = 3'd3,
    AND    = 3'd4,
    OR     = 3'd5,
    CARRY  = 3'd6,
    BUFFER = 3'd7
  } fba_func_t;

endpackage

// File: rtl/fba_alu_if.sv
// rtl/fba_alu_if.sv - serial operand/result bundle for fba_alu; FBA_ALU_CLR_EN adds clr
interface fba_alu_if
  import fba_pkg::*;
  ();

  logic                  A;
  logic                  B;
  // Plain vector rather than the enum so an undriven/X select stays observable.
  logic [FBA_FUNC_W-1:0] func;
  logic                  out;
  logic                  c_out;
`ifdef FBA_ALU_CLR_EN
  logic                  clr;
`endif

  modport master (
    output A, B, func,
`ifdef FBA_ALU_CLR_EN
    output clr,
`endif
    input  out, c_out
  );

  modport slave (
    input  A, B, func,
`ifdef FBA_ALU_CLR_EN
    input  clr,
`endif
    output out, c_out
  );

endinterface

// File: rtl/fba_full_adder.sv
// rtl/fba_full_adder.sv - combinational 1-bit full adder cell (sum s, carry g)
module fba_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic g_o
);

  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ cin_i;
  assign g_o = (a_i & b_i) | (p & cin_i);

endmodule

// File: rtl/fba_alu.sv
// rtl/fba_alu.sv - bit-serial function-block ALU with a chained carry flop
// FBA_ALU_CLR_EN: adds a synchronous carry clear input on the interface.
module fba_alu
  import fba_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  fba_alu_if.slave  bus
);

  logic c_q;
  logic c_d;
  logic s;
  logic g;
  logic out_w;

  fba_full_adder u_fa (
    .a_i   (bus.A),
    .b_i   (bus.B),
    .cin_i (c_q),
    .s_o   (s),
    .g_o   (g)
  );

  // A zero-bit load cycle yields g=0, so the carry self-clears between words.
  always_comb begin
    c_d = g;
`ifdef FBA_ALU_CLR_EN
    if (bus.clr) begin
      c_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q <= 1'b0;
    end else begin
      c_q <= c_d;
    end
  end

  // Unmatched (including X) selects fall to the default and output 0.
  always_comb begin
    out_w = 1'b0;
    case (bus.func)
      XOR:     out_w = bus.A ^ bus.B;
      XNOR:    out_w = ~(bus.A ^ bus.B);
      SUM:     out_w = s;
      NOT:     out_w = ~bus.A;
      AND:     out_w = bus.A & bus.B;
      OR:      out_w = bus.A | bus.B;
      CARRY:   out_w = g;
      BUFFER:  out_w = bus.A;
      default: out_w = 1'b0;
    endcase
  end

  assign bus.out   = out_w;
  assign bus.c_out = c_q;

endmodule

// File: tb/tb_fba_alu.sv
// tb/tb_fba_alu.sv - directed self-checking bench for fba_alu with modelled 8-bit shifters
module tb_fba_alu;
  import fba_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  logic [7:0] cap;
  logic [7:0] exp_b;

  fba_alu_if bus ();

  fba_alu dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  // One load cycle (A=B=0), then n shift cycles; result shifter enters at the MSB.
  task automatic run_word(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                          input int n, output logic [7:0] c);
    bus.func = f;
    bus.A    = 1'b0;
    bus.B    = 1'b0;
    @(posedge clk); #1;
    c = 8'h00;
    for (int k = 0; k < n; k++) begin
      bus.A = (k < 8) ? a[k] : 1'b0;
      bus.B = (k < 8) ? b[k] : 1'b0;
      #1;
      c = {bus.out, c[7:1]};
      @(posedge clk); #1;
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n    = 1'b0;
    bus.A    = 1'b0;
    bus.B    = 1'b0;
    bus.func = XNOR;
`ifdef FBA_ALU_CLR_EN
    bus.clr  = 1'b0;
`endif
    #12;
    check("reset_c_out", {7'd0, bus.c_out}, 8'h00);
    check("reset_xnor_out", {7'd0, bus.out}, 8'h01);
    @(posedge clk); #1;
    rst_n = 1'b1;

    bus.func = 3'bxxx;
    bus.A = 1'b1;
    bus.B = 1'b1;
    #1;
    check("xfunc_out", {7'd0, bus.out}, 8'h00);
    @(posedge clk); #1;
    check("xfunc_carry_upd", {7'd0, bus.c_out}, 8'h01);

    run_word(XOR,  8'hFF, 8'hFF, 8, cap); check("xor", cap, 8'h00);
    run_word(XNOR, 8'h00, 8'h00, 8, cap); check("xnor", cap, 8'hFF);
    run_word(AND,  8'hA5, 8'h3C, 8, cap); check("and", cap, 8'h24);
    run_word(OR,   8'hA5, 8'h3C, 8, cap); check("or", cap, 8'hBD);

    run_word(SUM, 8'hFF, 8'hFF, 8, cap);
    check("sum_ff_ff", cap, 8'hFE);
    check("sum_ff_ff_cout", {7'd0, bus.c_out}, 8'h01);
    run_word(SUM, 8'h12, 8'h34, 8, cap);
    check("sum_12_34", cap, 8'h46);
    check("sum_12_34_cout", {7'd0, bus.c_out}, 8'h00);

    run_word(CARRY, 8'h0F, 8'h01, 8, cap); check("carry", cap, 8'h0F);
    run_word(NOT,   8'h5A, 8'h00, 8, cap); check("not", cap, 8'hA5);

    for (int n = 1; n <= 16; n++) begin
      exp_b = (n <= 8) ? (8'hB3 << (8 - n)) : (8'hB3 >> (n - 8));
      run_word(BUFFER, 8'hB3, 8'h00, n, cap);
      check($sformatf("buffer_n%0d", n), cap, exp_b);
    end

    // Func switch mid-word: c=1 after 3 bits of FF+01
    run_word(SUM, 8'hFF, 8'h01, 3, cap);
    bus.func = XOR;
    bus.A = 1'b1;
    bus.B = 1'b0;
    #1;
    check("midword_xor", {7'd0, bus.out}, 8'h01);
    bus.func = SUM;
    #1;
    check("midword_sum", {7'd0, bus.out}, 8'h00);
    check("midword_c_kept", {7'd0, bus.c_out}, 8'h01);

    // Asynchronous reset mid-word
    run_word(SUM, 8'hFF, 8'h01, 4, cap);
    check("pre_reset_cout", {7'd0, bus.c_out}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_cout", {7'd0, bus.c_out}, 8'h00);
    #1;
    rst_n = 1'b1;
    bus.func = SUM;
    bus.A = 1'b1;
    bus.B = 1'b0;
    #1;
    check("post_reset_fresh", {7'd0, bus.out}, 8'h01);
    @(posedge clk); #1;
    check("post_reset_cout", {7'd0, bus.c_out}, 8'h00);

`ifdef FBA_ALU_CLR_EN
    run_word(SUM, 8'hFF, 8'h01, 2, cap);
    check("clr_pre_cout", {7'd0, bus.c_out}, 8'h01);
    bus.clr = 1'b1;
    bus.A = 1'b1;
    bus.B = 1'b0;
    #1;
    check("clr_out_unaffected", {7'd0, bus.out}, 8'h00);
    @(posedge clk); #1;
    bus.clr = 1'b0;
    check("clr_cout", {7'd0, bus.c_out}, 8'h00);
    #1;
    check("clr_out_axb", {7'd0, bus.out}, 8'h01);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
